// File: rtl/codec2_arb_pkg.sv
// Shared types for the multiplier-pair arbiter.
// State encoding and index-width helper.
package codec2_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  localparam int NREQ_MIN = 2;
  localparam int NREQ_MAX = 8;

  // Width of owner/ptr indices for a given requester count.
  function automatic int idx_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/qmult_pair_arbiter_rr_pick.sv
// Round-robin picker: first requester at or
// after ptr, wrapping modulo NREQ.
module rr_pick
  import codec2_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  int cand;

  // Scan from the far end so the slot nearest ptr is written last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (req[cand]) begin
        valid = 1'b1;
        idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/qmult_pair_arbiter.sv
// Lock-style arbiter sharing the m1/m2 qmult pair.
// Optional watchdog: define MULT_ARB_TIMEOUT_EN.
module qmult_pair_arbiter
  import codec2_arb_pkg::*;
#(
  parameter int N        = 32,
  parameter int Q        = 16,
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  input  logic [NREQ*N-1:0] rq_m1_in1,
  input  logic [NREQ*N-1:0] rq_m1_in2,
  input  logic [NREQ*N-1:0] rq_m2_in1,
  input  logic [NREQ*N-1:0] rq_m2_in2,
  output logic [N-1:0]      m1_in1,
  output logic [N-1:0]      m1_in2,
  output logic [N-1:0]      m2_in1,
  output logic [N-1:0]      m2_in2,
  input  logic [N-1:0]      m1_out,
  input  logic [N-1:0]      m2_out,
  output logic [N-1:0]      p1,
  output logic [N-1:0]      p2
`ifdef MULT_ARB_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  localparam int IW = idx_w(NREQ);

  if (NREQ < NREQ_MIN || NREQ > NREQ_MAX) begin : g_bad_nreq
    $error("qmult_pair_arbiter: NREQ out of range");
  end
  if (Q < 1 || Q >= N) begin : g_bad_q
    $error("qmult_pair_arbiter: Q must be in 1..N-1");
  end
  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("qmult_pair_arbiter: MAX_HOLD must be >= 1");
  end

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;

  logic [NREQ-1:0] req_ok;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic            own_req;
  logic            expire;

  assign own_req = req[owner_q];

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0]   hold_q, hold_d;
  logic [NREQ-1:0] mask_q, mask_d;
  logic            terr_q, terr_d;

  assign expire = (state_q == ST_GRANT) && own_req
               && (hold_q == HW'(MAX_HOLD - 1));

  assign req_ok = req & ~mask_q;

  // Hold counter, revoked-owner mask and sticky error.
  always_comb begin
    hold_d = '0;
    if (state_q == ST_GRANT) begin
      hold_d = hold_q + 1'b1;
    end
    mask_d = mask_q & req;
    if (expire) begin
      mask_d[owner_q] = 1'b1;
    end
    terr_d = terr_q | expire;
  end

  // Watchdog registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= '0;
      mask_q <= '0;
      terr_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      mask_q <= mask_d;
      terr_q <= terr_d;
    end
  end

  assign timeout_err = terr_q;
`else
  assign expire = 1'b0;
  assign req_ok = req;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (req_ok),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Grant FSM: arbitrate in IDLE, hold in GRANT, one dead cycle in DRAIN.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (pick_valid) begin
          owner_d = pick_idx;
          gnt_d   = NREQ'(1) << pick_idx;
          ptr_d   = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!own_req || expire) begin
          gnt_d   = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, owner, pointer and grant registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
    end
  end

  // Steer the owner's operand slices; zero outside GRANT.
  always_comb begin
    m1_in1 = '0;
    m1_in2 = '0;
    m2_in1 = '0;
    m2_in2 = '0;
    if (state_q == ST_GRANT) begin
      m1_in1 = rq_m1_in1[int'(owner_q)*N +: N];
      m1_in2 = rq_m1_in2[int'(owner_q)*N +: N];
      m2_in1 = rq_m2_in1[int'(owner_q)*N +: N];
      m2_in2 = rq_m2_in2[int'(owner_q)*N +: N];
    end
  end

  assign gnt  = gnt_q;
  assign busy = |gnt_q;
  assign p1   = m1_out;
  assign p2   = m2_out;

endmodule

// File: tb/tb_qmult_pair_arbiter.sv
// Directed + randomized bench for qmult_pair_arbiter.
// Watchdog steps compile in with MULT_ARB_TIMEOUT_EN.
module tb_qmult_pair_arbiter;

  localparam int N    = 32;
  localparam int Q    = 16;
  localparam int NREQ = 4;
  localparam int MH   = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic [NREQ*N-1:0] rq_m1_in1, rq_m1_in2, rq_m2_in1, rq_m2_in2;
  logic [N-1:0]      m1_in1, m1_in2, m2_in1, m2_in2;
  logic [N-1:0]      m1_out, m2_out, p1, p2;
`ifdef MULT_ARB_TIMEOUT_EN
  logic              terr;
`endif

  logic [N-1:0] op [4][NREQ];
  bit           rand_on;

  always_comb begin
    rq_m1_in1 = '0;
    rq_m1_in2 = '0;
    rq_m2_in1 = '0;
    rq_m2_in2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      rq_m1_in1[i*N +: N] = op[0][i];
      rq_m1_in2[i*N +: N] = op[1][i];
      rq_m2_in1[i*N +: N] = op[2][i];
      rq_m2_in2[i*N +: N] = op[3][i];
    end
  end

  function automatic logic [N-1:0] qm(input logic [N-1:0] a,
                                       input logic [N-1:0] b);
    logic signed [2*N-1:0] pr;
    pr = $signed({{N{a[N-1]}}, a}) * $signed({{N{b[N-1]}}, b});
    return pr[Q +: N];
  endfunction

  assign m1_out = qm(m1_in1, m1_in2);
  assign m2_out = qm(m2_in1, m2_in2);

  qmult_pair_arbiter #(
    .N        (N),
    .Q        (Q),
    .NREQ     (NREQ),
    .MAX_HOLD (MH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .busy      (busy),
    .rq_m1_in1 (rq_m1_in1),
    .rq_m1_in2 (rq_m1_in2),
    .rq_m2_in1 (rq_m2_in1),
    .rq_m2_in2 (rq_m2_in2),
    .m1_in1    (m1_in1),
    .m1_in2    (m1_in2),
    .m2_in1    (m2_in1),
    .m2_in2    (m2_in2),
    .m1_out    (m1_out),
    .m2_out    (m2_out),
    .p1        (p1),
    .p2        (p2)
`ifdef MULT_ARB_TIMEOUT_EN
    ,
    .timeout_err (terr)
`endif
  );

  int tests = 0;
  int fails = 0;
  int g1_hits = 0;

  // Reference model: who owns, cycles until arbitration, last winner.
  int            m_owner = -1;
  int            m_cool  = 0;
  int            m_last  = NREQ - 1;
  int            m_hold  = 0;
  bit [NREQ-1:0] m_block = '0;
  bit            m_terr  = 1'b0;

  task automatic chk(input string tag, input logic [N-1:0] obs,
                     input logic [N-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (!rst) begin
      m_owner = -1;
      m_cool  = 0;
      m_last  = NREQ - 1;
      m_hold  = 0;
      m_block = '0;
      m_terr  = 1'b0;
      return;
    end
`ifdef MULT_ARB_TIMEOUT_EN
    m_block = m_block & req;
`endif
    if (m_owner >= 0) begin
      bit rel;
      rel = !req[m_owner];
      m_hold++;
`ifdef MULT_ARB_TIMEOUT_EN
      if (!rel && m_hold >= MH) begin
        rel = 1'b1;
        m_terr = 1'b1;
        m_block[m_owner] = 1'b1;
      end
`endif
      if (rel) begin
        m_owner = -1;
        m_cool  = 1;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_last + k) % NREQ;
        if (req[c] && !m_block[c]) begin
          m_owner = c;
          m_last  = c;
          m_hold  = 0;
          break;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [N-1:0] x [4];
    logic [N-1:0] eg;
    eg = '0;
    for (int j = 0; j < 4; j++) x[j] = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      for (int j = 0; j < 4; j++) x[j] = op[j][m_owner];
    end
    chk("gnt", N'(gnt), eg);
    chk("busy", N'(busy), N'(m_owner >= 0));
    chk("m1_in1", m1_in1, x[0]);
    chk("m1_in2", m1_in2, x[1]);
    chk("m2_in1", m2_in1, x[2]);
    chk("m2_in2", m2_in2, x[3]);
    chk("p1", p1, qm(x[0], x[1]));
    chk("p2", p2, qm(x[2], x[3]));
`ifdef MULT_ARB_TIMEOUT_EN
    chk("timeout_err", N'(terr), N'(m_terr));
`endif
  endtask

  task automatic rand_ops();
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < NREQ; i++)
        op[j][i] = $urandom();
  endtask

  // One clock: model steps on the edge, DUT checked on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
    if (gnt[1]) g1_hits++;
    if (rand_on) rand_ops();
  endtask

  task automatic wait_gnt(output int who, output int zeros);
    who = -1;
    zeros = 0;
    for (int k = 0; k < 20; k++) begin
      if (gnt != '0) begin
        for (int i = 0; i < NREQ; i++)
          if (gnt[i]) who = i;
        break;
      end
      zeros++;
      cycle();
    end
    chk("wait_gnt_found", N'(who >= 0), N'(1));
  endtask

  initial begin
    int who, zeros, prev, hold, b;
    req = '0;
    rand_on = 1'b0;
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < NREQ; i++)
        op[j][i] = '0;

    // Reset state
    repeat (2) cycle();
    chk("rst_gnt", N'(gnt), N'(0));
    chk("rst_busy", N'(busy), N'(0));
    chk("rst_m1_in1", m1_in1, N'(0));
    rst = 1'b1;

    // Single requester: 2.0 * 3.0
    op[0][0] = 32'h0002_0000;
    op[1][0] = 32'h0003_0000;
    req = 4'b0001;
    cycle();
    chk("single_gnt", N'(gnt), N'(4'b0001));
    chk("single_m1_in1", m1_in1, 32'h0002_0000);
    chk("single_p1", p1, 32'h0006_0000);
    repeat (2) cycle();
    req = 4'b0000;
    cycle();
    chk("drain_gnt", N'(gnt), N'(0));
    chk("drain_m1_in1", m1_in1, N'(0));
    chk("drain_m1_in2", m1_in2, N'(0));
    repeat (2) cycle();

    // Simultaneous requests from reset
    rand_on = 1'b1;
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    req = 4'b1111;
    for (int n = 0; n < NREQ; n++) begin
      wait_gnt(who, zeros);
      chk("sim_order", N'(who), N'(n));
      chk("sim_gap", N'(zeros), N'((n == 0) ? 1 : 2));
      repeat (4) cycle();
      if (who >= 0) req[who] = 1'b0;
      cycle();
    end
    req = '0;
    repeat (3) cycle();

    // Round-robin fairness between 0 and 2
    req = 4'b0101;
    prev = -1;
    for (int r = 0; r < 4; r++) begin
      wait_gnt(who, zeros);
      chk("rr_order", N'(who), N'((r % 2 == 0) ? 0 : 2));
      chk("rr_no_repeat", N'(who != prev), N'(1));
      prev = who;
      repeat (2) cycle();
      if (who >= 0) req[who] = 1'b0;
      cycle();
      if (who >= 0) req[who] = 1'b1;
    end
    req = '0;
    repeat (4) cycle();

    // Short pulse on req[1] while 0 owns
    g1_hits = 0;
    req = 4'b0001;
    wait_gnt(who, zeros);
    chk("pulse_owner", N'(who), N'(0));
    cycle();
    req[1] = 1'b1;
    cycle();
    req[1] = 1'b0;
    repeat (2) cycle();
    req[0] = 1'b0;
    repeat (6) cycle();
    chk("pulse_no_gnt1", N'(g1_hits), N'(0));

    // Asynchronous reset in the middle of a grant
    req = 4'b0100;
    wait_gnt(who, zeros);
    chk("mid_owner", N'(who), N'(2));
    cycle();
    #2 rst = 1'b0;
    #1;
    chk("async_gnt", N'(gnt), N'(0));
    chk("async_busy", N'(busy), N'(0));
    chk("async_m1_in1", m1_in1, N'(0));
    chk("async_m2_in2", m2_in2, N'(0));
    req = 4'b1111;
    cycle();
    rst = 1'b1;
    wait_gnt(who, zeros);
    chk("post_rst_owner", N'(who), N'(0));
    req = '0;
    repeat (3) cycle();

    // Randomized request traffic against the model
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(3) == 0) begin
        b = $urandom_range(NREQ - 1);
        req[b] = ~req[b];
      end
      cycle();
    end
    req = '0;
    repeat (4) cycle();

`ifdef MULT_ARB_TIMEOUT_EN
    // Watchdog revokes a stuck owner
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    req = 4'b0011;
    wait_gnt(who, zeros);
    chk("wd_first", N'(who), N'(0));
    hold = 0;
    for (int k = 0; k < 20; k++) begin
      if (!gnt[0]) break;
      hold++;
      cycle();
    end
    chk("wd_hold_len", N'(hold), N'(MH));
    chk("wd_err", N'(terr), N'(1));
    wait_gnt(who, zeros);
    chk("wd_next", N'(who), N'(1));
    repeat (3) cycle();
    req[1] = 1'b0;
    repeat (6) begin
      cycle();
      chk("wd_masked", N'(gnt), N'(0));
    end
    req[0] = 1'b0;
    cycle();
    req[0] = 1'b1;
    wait_gnt(who, zeros);
    chk("wd_regrant", N'(who), N'(0));
    chk("wd_err_sticky", N'(terr), N'(1));
    req = '0;
    repeat (3) cycle();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/qmult_pair_arbiter.md
# qmult_pair_arbiter

Shares the encoder's pair of Q16.16 fixed-point multipliers (m1, m2) between up to NREQ sequencing FSMs, such as the pitch-refinement and harmonic-energy stages, that each expose `m1_in1/m1_in2/m2_in1/m2_in2` operand ports. A requester holds a lock-style grant for as many cycles as it needs. The arbiter steers the owner's operands to the shared multipliers and broadcasts both products to all requesters. It sits in the encoder top level, between the stage FSMs and the two `qmult` instances.

## Interface
Parameters:
- `N`, 32: data word width (1 sign, 15 integer, 16 fraction bits).
- `Q`, 16: fraction bits; passed through to the shared `qmult` instances.
- `NREQ`, 4: number of requesters; legal range 2–8.
- `MAX_HOLD`, 1023: watchdog hold limit in cycles; used only with `MULT_ARB_TIMEOUT_EN`.

Ports:
- `clk` input, 1: clock.
- `rst` input, 1: reset, asynchronous, active-low.
- `req` input, NREQ: per-requester request; held high for the whole ownership.
- `gnt` output, NREQ: one-hot grant, registered.
- `busy` output, 1: high whenever any grant is held.
- `rq_m1_in1`, `rq_m1_in2`, `rq_m2_in1`, `rq_m2_in2` input, NREQ*N each: flattened operand buses; requester i occupies bits `[i*N +: N]`.
- `m1_in1`, `m1_in2`, `m2_in1`, `m2_in2` output, N each: operands to the shared multipliers.
- `m1_out`, `m2_out` input, N each: products from the shared multipliers.
- `p1`, `p2` output, N each: products broadcast to all requesters.
- `timeout_err` output, 1: sticky watchdog flag; present only with `MULT_ARB_TIMEOUT_EN`.

## Operation
- State machine, three states:
  - IDLE: `gnt`=0. If any `req` bit is high, latch the winner index into `owner`, set `gnt[winner]`, go to GRANT.
  - GRANT: while `req[owner]`=1, stay in GRANT. When `req[owner]`=0, clear `gnt` and go to DRAIN.
  - DRAIN: exactly one cycle with `gnt`=0. Then IDLE rules apply: the next arbitration happens at the DRAIN→IDLE edge, using `req` sampled in DRAIN.
- Winner selection is round-robin. The search starts at `ptr`, where `ptr` = (last owner + 1) mod NREQ; `ptr` resets to 0. `ptr` updates when a grant is issued.
- Operand mux (combinational from the `owner` register):
  - In GRANT, `m*_in*` carry the owner's operand slices.
  - In IDLE and DRAIN, `m*_in*` are forced to 0.
- `p1`=`m1_out` and `p2`=`m2_out`, combinational pass-through. A requester consumes a product only while its own `gnt` bit is high.
- `req` bits of non-owners are ignored during GRANT and DRAIN; they are not queued, only re-sampled.
- A `req` pulse that falls before the arbitration edge receives no grant.
- Operands are never modified or saturated; width is N in and N out.

## Timing
- Reset values: `gnt`=0, `busy`=0, `owner`=0, `ptr`=0, all `m*_in*`=0, `timeout_err`=0, state IDLE. Reset mid-operation revokes the grant immediately (asynchronous).
- Grant latency: `req` rises in cycle t while in IDLE → `gnt` high from cycle t+1.
- Release: `req[owner]` falls in cycle t → `gnt` low at t+1 (DRAIN) → IDLE at t+2. The earliest new grant is at t+3.
- Multiplier path is combinational: owner operands registered at edge k reach the owner on `p1`/`p2` in cycle k. This preserves the single-cycle operand-to-`*_out` usage inside the stage FSMs.
- Simultaneous requests: the first requester at or after `ptr` wins; the others remain pending while they hold `req`.

## Configuration
- `MULT_ARB_TIMEOUT_EN` defined:
  - A hold counter increments each GRANT cycle and clears on entry to GRANT.
  - When the count reaches `MAX_HOLD`, the grant is revoked and the block enters DRAIN as if the owner had released.
  - `timeout_err` is set and stays set until reset.
  - The revoked owner must drop `req` before it can be granted again; a still-high `req` is masked until it has been seen low.
- `MULT_ARB_TIMEOUT_EN` undefined: no counter and no `timeout_err` port; ownership is unbounded.

## Structure
- Shared package `codec2_arb_pkg` holds:
  - the state encoding (IDLE, GRANT, DRAIN);
  - the `owner`/`ptr` index width, computed as $clog2(NREQ).
- One sub-module, `rr_pick`: combinational round-robin picker. Inputs are `req` and `ptr`; outputs are a `valid` flag and the winner index.
- Multipliers stay outside the block (existing `qmult`).

## Test plan
- Single requester, full cycle:
  - Stimulus: reset; `req`=0001, with requester 0 operands m1 = 2.0 × 3.0 (0x00020000, 0x00030000).
  - Required: `gnt`=0001 one cycle after `req`; `m1_in1`=0x00020000; `p1` matches `qmult` 0x00060000.
  - Release: drop `req` → `gnt`=0 next cycle; all `m*_in*`=0 during DRAIN.
- Simultaneous requests:
  - Stimulus: `req`=1111 from reset.
  - Required: grants in order 0, 1, 2, 3 as each owner releases after 5 cycles; 2 zero-`gnt` cycles between owners.
- Round-robin fairness:
  - Stimulus: requesters 0 and 2 continuously re-request, each holding 3 cycles.
  - Required: grants alternate 0, 2, 0, 2; requester 0 never wins twice in a row.
- Short pulse:
  - Stimulus: `req[1]` high for one cycle while requester 0 owns the multipliers.
  - Required: requester 1 is never granted.
- Reset mid-grant:
  - Stimulus: assert `rst`=0 during GRANT.
  - Required: `gnt`, `busy`, and `m*_in*` go to 0 without waiting for a clock edge; after release, `ptr`=0 so requester 0 wins first.
- Watchdog (with `MULT_ARB_TIMEOUT_EN`, `MAX_HOLD`=8):
  - Stimulus: requester 0 holds `req` indefinitely while `req[1]` is also high.
  - Required: grant revoked after 8 GRANT cycles; `timeout_err`=1; requester 1 granted next; requester 0 is not regranted until its `req` toggles low.
